// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single GRF write port between the writeback
// stage (A, never stalled, always wins) and a late-writeback source
// (B, valid/ready, buffered in a small in-order FIFO that drains when A is
// idle). It also reports pending B writes to the hazard unit.

// Per-entry register match: compares one FIFO slot against the two decode
// queries and the current A destination.
module grf_wb_ent_match (
  input  logic       vld,
  input  logic [4:0] ent_a3,
  input  logic [4:0] q_a1,
  input  logic [4:0] q_a2,
  input  logic [4:0] wb_a3,
  output logic       hit1,
  output logic       hit2,
  output logic       hit_wb
);
  assign hit1   = vld && (ent_a3 == q_a1);
  assign hit2   = vld && (ent_a3 == q_a2);
  assign hit_wb = vld && (ent_a3 == wb_a3);
endmodule

module grf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic [31:0] wb_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        busy1,
  output logic        busy2,
  output logic        drain_req,
  output logic        conflict,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                conflict_q, conflict_d;

  logic [DEPTH-1:0]    ent_vld, hit1, hit2, hit_wb;
  logic                a_grant, fifo_empty, pop, push;
  wb_ent_t             head;

  // Slot i holds a live entry when its distance from the read pointer is
  // below the count; pointer subtraction wraps because DEPTH is a power of 2.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr_q;
    assign ent_vld[i] = CW'(off) < cnt_q;
    grf_wb_ent_match u_match (
      .vld    (ent_vld[i]),
      .ent_a3 (mem_q[i].a3),
      .q_a1   (q_a1),
      .q_a2   (q_a2),
      .wb_a3  (wb_a3),
      .hit1   (hit1[i]),
      .hit2   (hit2[i]),
      .hit_wb (hit_wb[i])
    );
  end

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign a_grant    = wb_valid && (wb_a3 != 5'd0);
  assign pop        = !a_grant && !fifo_empty;
  // Ready comes from registered count only: no pass-through when full.
  assign mdu_ready  = (cnt_q < CW'(DEPTH));
  assign push       = mdu_valid && mdu_ready && (mdu_a3 != 5'd0);

  assign busy1      = (q_a1 != 5'd0) && (|hit1);
  assign busy2      = (q_a2 != 5'd0) && (|hit2);
  assign drain_req  = (cnt_q == CW'(DEPTH));
  assign conflict   = conflict_q;

  // Write-port mux: A first, then FIFO head, otherwise fully zeroed.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (a_grant) begin
      grf_we = 1'b1;
      grf_a3 = wb_a3;
      grf_wd = wb_wd;
      grf_pc = wb_pc;
    end else if (pop) begin
      grf_we = 1'b1;
      grf_a3 = head.a3;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end
  end

  // FIFO pointer/count/storage update and sticky conflict detection.
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{a3: mdu_a3, wd: mdu_wd, pc: mdu_pc};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (a_grant && (|hit_wb)) conflict_d = 1'b1;
  end

  // Control state: synchronous reset discards all pending entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  // Entry storage needs no reset; liveness is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter (DEPTH=2): inputs change 1ns after the
// rising edge, outputs are checked 1ns after the inputs settle.
module tb_grf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd, wb_pc;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd, mdu_pc;
  logic [4:0]  q_a1, q_a2;
  logic        busy1, busy2, drain_req, conflict;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .q_a1(q_a1), .q_a2(q_a2), .busy1(busy1), .busy2(busy2),
    .drain_req(drain_req), .conflict(conflict),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_a3 = '0; wb_wd = '0; wb_pc = '0;
    mdu_valid = 1'b0; mdu_a3 = '0; mdu_wd = '0; mdu_pc = '0;
    q_a1 = 5'd8; q_a2 = 5'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    // reset state / idle
    chk("rst_we", grf_we, 0);
    chk("rst_a3", grf_a3, 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_drain", drain_req, 0);
    chk("rst_conflict", conflict, 0);

    // A only, zero latency
    wb_valid = 1'b1; wb_a3 = 5'd5; wb_wd = 32'h1234; wb_pc = 32'h3000;
    #1;
    chk("a_we", grf_we, 1);
    chk("a_a3", grf_a3, 5);
    chk("a_wd", grf_wd, 32'h1234);
    chk("a_pc", grf_pc, 32'h3000);
    wb_a3 = 5'd0;
    #1;
    chk("a0_we", grf_we, 0);
    chk("a0_wd", grf_wd, 0);
    chk("a0_pc", grf_pc, 0);
    wb_valid = 1'b0;

    // B enqueue then drain, no bypass
    mdu_valid = 1'b1; mdu_a3 = 5'd8; mdu_wd = 32'hAA; mdu_pc = 32'h4000;
    #1;
    chk("b_nobypass_we", grf_we, 0);
    chk("b_pre_busy1", busy1, 0);
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("b_busy1", busy1, 1);
    chk("b_we", grf_we, 1);
    chk("b_a3", grf_a3, 8);
    chk("b_wd", grf_wd, 32'hAA);
    chk("b_pc", grf_pc, 32'h4000);
    tick();
    chk("b_post_busy1", busy1, 0);
    chk("b_post_we", grf_we, 0);

    // Priority and fill
    wb_valid = 1'b1; wb_a3 = 5'd3; wb_wd = 32'h33; wb_pc = 32'h5000;
    mdu_valid = 1'b1; mdu_a3 = 5'd9; mdu_wd = 32'h99; mdu_pc = 32'h9000;
    q_a1 = 5'd9; q_a2 = 5'd10;
    tick();
    mdu_a3 = 5'd10; mdu_wd = 32'h100; mdu_pc = 32'h9004;
    #1;
    chk("fill1_ready", mdu_ready, 1);
    chk("fill1_a3", grf_a3, 3);
    tick();
    mdu_a3 = 5'd11; mdu_wd = 32'h111; mdu_pc = 32'h9008;
    #1;
    chk("full_drain", drain_req, 1);
    chk("full_ready", mdu_ready, 0);
    chk("full_a_a3", grf_a3, 3);
    chk("full_busy1", busy1, 1);
    chk("full_busy2", busy2, 1);
    tick();
    chk("full2_ready", mdu_ready, 0);
    chk("full2_drain", drain_req, 1);
    mdu_valid = 1'b0;
    wb_a3 = 5'd0;             // A with a3=0 leaves the port to B
    #1;
    chk("dr1_we", grf_we, 1);
    chk("dr1_a3", grf_a3, 9);
    chk("dr1_wd", grf_wd, 32'h99);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("dr2_a3", grf_a3, 10);
    chk("dr2_pc", grf_pc, 32'h9004);
    chk("dr2_ready", mdu_ready, 1);
    chk("dr2_drain", drain_req, 0);
    chk("dr2_busy1", busy1, 0);
    chk("dr2_busy2", busy2, 1);
    tick();
    q_a1 = 5'd11;
    #1;
    chk("dr3_we", grf_we, 0);
    chk("dr3_busy2", busy2, 0);
    chk("dr3_no11", busy1, 0);

    // Simultaneous enqueue and pop
    mdu_valid = 1'b1; mdu_a3 = 5'd4; mdu_wd = 32'h44; mdu_pc = 32'h6000;
    tick();
    mdu_a3 = 5'd6; mdu_wd = 32'h66; mdu_pc = 32'h6004;
    q_a1 = 5'd4; q_a2 = 5'd6;
    #1;
    chk("sim_a3", grf_a3, 4);
    chk("sim_ready", mdu_ready, 1);
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("sim2_a3", grf_a3, 6);
    chk("sim2_wd", grf_wd, 32'h66);
    chk("sim2_busy4", busy1, 0);
    chk("sim2_busy6", busy2, 1);
    chk("sim2_drain", drain_req, 0);
    tick();
    chk("sim3_we", grf_we, 0);

    // Handshake with a3=0 is discarded
    mdu_valid = 1'b1; mdu_a3 = 5'd0; mdu_wd = 32'hDEAD;
    tick();
    mdu_valid = 1'b0;
    #1;
    chk("disc_we", grf_we, 0);
    chk("disc_ready", mdu_ready, 1);

    // Conflict then reset mid-operation
    wb_valid = 1'b1; wb_a3 = 5'd2; wb_wd = 32'h22; wb_pc = 32'h7000;
    mdu_valid = 1'b1; mdu_a3 = 5'd7; mdu_wd = 32'h70; mdu_pc = 32'h7100;
    q_a1 = 5'd7; q_a2 = 5'd12;
    tick();
    mdu_valid = 1'b0;
    wb_a3 = 5'd7; wb_wd = 32'h77;
    #1;
    chk("cf_we", grf_we, 1);
    chk("cf_a3", grf_a3, 7);
    chk("cf_wd", grf_wd, 32'h77);
    chk("cf_pre", conflict, 0);
    tick();
    wb_a3 = 5'd2; wb_wd = 32'h22;
    #1;
    chk("cf_set", conflict, 1);
    tick();
    chk("cf_sticky", conflict, 1);
    chk("cf_busy7", busy1, 1);
    reset = 1'b1;
    mdu_valid = 1'b1; mdu_a3 = 5'd12; mdu_wd = 32'hC0;
    tick();
    reset = 1'b0; mdu_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("rr_conflict", conflict, 0);
    chk("rr_busy7", busy1, 0);
    chk("rr_busy12", busy2, 0);
    chk("rr_we", grf_we, 0);
    chk("rr_ready", mdu_ready, 1);
    chk("rr_drain", drain_req, 0);
    tick();
    chk("rr2_we", grf_we, 0);
    chk("rr2_a3", grf_a3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
